// File: rtl/shaper_pkg.sv
// Shared types and helpers for the pulse peak detection path.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: n/a; sat_inc keeps event/drop counters pinned at all-ones.
package shaper_pkg;

  localparam int DW_DEF    = 14;
  localparam int TS_W_DEF  = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RISE   = 2'd1,
    HOLD   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Increment v unless it already sits at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/peak_out_buffer.sv
// Single-entry event register between the detector FSM and the histogram stage.
// Latency: a load shows on peak_valid the cycle after the load request.
// Backpressure: a load is taken only if the slot is empty or drains this cycle, otherwise it is counted as a drop.
module peak_out_buffer
  import shaper_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DW-1:0]    load_height,
  input  logic [TS_W-1:0]  load_time,
  input  logic             load_pileup,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [DW-1:0]    peak_height,
  output logic [TS_W-1:0]  peak_time,
  output logic             peak_pileup,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] drop_count
);

  logic accept;
  logic load_ok;

  // Ready is only meaningful while an event is being presented.
  assign accept  = peak_valid & peak_ready;
  // The slot frees up in the same cycle it is accepted, so accept+load back-to-back is lossless.
  assign load_ok = load & (~peak_valid | accept);

  // Output register, handshake state and event/drop counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      peak_valid  <= 1'b0;
      peak_height <= '0;
      peak_time   <= '0;
      peak_pileup <= 1'b0;
      event_count <= '0;
      drop_count  <= '0;
    end else begin
      if (load_ok) begin
        peak_valid  <= 1'b1;
        peak_height <= load_height;
        peak_time   <= load_time;
        peak_pileup <= load_pileup;
        event_count <= CNT_W'(sat_inc(32'(event_count), CNT_W));
      end else if (accept) begin
        peak_valid <= 1'b0;
      end
      if (load && !load_ok) begin
        drop_count <= CNT_W'(sat_inc(32'(drop_count), CNT_W));
      end
    end
  end

endmodule

// File: rtl/pulse_peak_detector.sv
// Threshold pulse detector: tracks the first maximum of each pulse, its timestamp and pile-up.
// Latency: peak_valid rises HOLDOFF+2 cycles after the first below-threshold registered sample.
// Backpressure: one-entry output buffer; events finishing while it is still occupied are dropped and counted.
module pulse_peak_detector
  import shaper_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int HOLDOFF   = 16,
  parameter int MAX_WIDTH = 420,
  parameter int TS_W      = TS_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DW-1:0]    shaped_in,
  input  logic [DW-1:0]    thresh,
  output logic             peak_valid,
  input  logic             peak_ready,
  output logic [DW-1:0]    peak_height,
  output logic [TS_W-1:0]  peak_time,
  output logic             peak_pileup,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int HW = $clog2(HOLDOFF + 1);

  state_t          state;
  logic [DW-1:0]   s_q;
  logic [TS_W-1:0] s_tag;
  logic [TS_W-1:0] ts;
  logic [DW-1:0]   max_v;
  logic [TS_W-1:0] max_ts;
  logic [WW-1:0]   width;
  logic [WW-1:0]   width_inc;
  logic [HW-1:0]   hcnt;
  logic            pile;
  logic            trigger;
  logic            new_max;
  logic            width_full;
  logic            commit;

  // Samples and thresholds are two's complement; compare them as signed values.
  assign trigger    = $signed(s_q) > $signed(thresh);
  // Strict compare so a flat top keeps the timestamp of its first sample.
  assign new_max    = $signed(s_q) > $signed(max_v);
  // Width saturates at MAX_WIDTH; pile-up is latched once it gets there.
  assign width_inc  = (width >= WW'(MAX_WIDTH)) ? width : width + WW'(1);
  assign width_full = width_inc >= WW'(MAX_WIDTH);
  // A disabled cycle abandons even an event that has reached COMMIT.
  assign commit     = enable && (state == COMMIT);

  // Input register and free-running timestamp; each sample carries the count at capture time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ts    <= '0;
      s_q   <= '0;
      s_tag <= '0;
    end else begin
      ts    <= ts + TS_W'(1);
      s_q   <= shaped_in;
      s_tag <= ts;
    end
  end

  // Pulse FSM: start on trigger, follow the maximum, wait HOLDOFF quiet cycles, then commit once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      max_v  <= '0;
      max_ts <= '0;
      width  <= '0;
      pile   <= 1'b0;
      hcnt   <= '0;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state  <= RISE;
            max_v  <= s_q;
            max_ts <= s_tag;
            width  <= WW'(1);
            pile   <= 1'b0;
          end
        end
        RISE: begin
          if (trigger) begin
            width <= width_inc;
            if (width_full) pile <= 1'b1;
            if (new_max) begin
              max_v  <= s_q;
              max_ts <= s_tag;
            end
          end else begin
            state <= HOLD;
            hcnt  <= '0;
          end
        end
        HOLD: begin
          if (trigger) begin
            // A second crossing inside the hold-off window merges into this event as pile-up.
            state <= RISE;
            pile  <= 1'b1;
            width <= width_inc;
            if (new_max) begin
              max_v  <= s_q;
              max_ts <= s_tag;
            end
          end else if (hcnt == HW'(HOLDOFF - 1)) begin
            state <= COMMIT;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        COMMIT: begin
          // Any trigger in this cycle is ignored; IDLE looks at the next sample.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  peak_out_buffer #(
    .DW    (DW),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) u_out (
    .clk         (clk),
    .rst         (rst),
    .load        (commit),
    .load_height (max_v),
    .load_time   (max_ts),
    .load_pileup (pile),
    .peak_valid  (peak_valid),
    .peak_ready  (peak_ready),
    .peak_height (peak_height),
    .peak_time   (peak_time),
    .peak_pileup (peak_pileup),
    .event_count (event_count),
    .drop_count  (drop_count)
  );

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Bench for pulse_peak_detector: directed pulse shapes plus randomized run streams.
// Events are derived offline from each whole sample array; the output slot is modelled per clock edge.
// All comparisons go through check_eq; one summary line at the end.
module tb_pulse_peak_detector;

  localparam int DW        = 14;
  localparam int HOLDOFF   = 16;
  localparam int MAX_WIDTH = 420;
  localparam int TS_W      = 32;
  localparam int CNT_W     = 16;
  localparam int MAXN      = 1500;
  localparam int MAXEV     = 256;

  logic             clk;
  logic             rst;
  logic             enable;
  logic [DW-1:0]    shaped_in;
  logic [DW-1:0]    thresh;
  logic             peak_valid;
  logic             peak_ready;
  logic [DW-1:0]    peak_height;
  logic [TS_W-1:0]  peak_time;
  logic             peak_pileup;
  logic [CNT_W-1:0] event_count;
  logic [CNT_W-1:0] drop_count;

  pulse_peak_detector #(
    .DW        (DW),
    .HOLDOFF   (HOLDOFF),
    .MAX_WIDTH (MAX_WIDTH),
    .TS_W      (TS_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .shaped_in   (shaped_in),
    .thresh      (thresh),
    .peak_valid  (peak_valid),
    .peak_ready  (peak_ready),
    .peak_height (peak_height),
    .peak_time   (peak_time),
    .peak_pileup (peak_pileup),
    .event_count (event_count),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Stimulus: sample m and ready m are presented to posedge m (m=0 is the first edge out of reset).
  // A sample therefore carries timestamp tag m.  en[m] is enable at posedge m; en[0] stays 0 so the
  // reset value of the input register is never taken as a sample.
  logic signed [DW-1:0] s   [MAXN];
  bit                   rdy [MAXN];
  bit                   en  [MAXN+1];
  int                   cmt_idx [MAXN];

  logic signed [DW-1:0] ev_h [MAXEV];
  int                   ev_t [MAXEV];
  bit                   ev_p [MAXEV];
  int                   n_ev;

  int                   wp;
  int                   rise_m;
  logic [DW-1:0]        d_h;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      s[i]   = '0;
      rdy[i] = 1'b0;
      en[i]  = 1'b1;
    end
    en[MAXN] = 1'b1;
    en[0]    = 1'b0;
    wp       = 0;
  endtask

  task automatic add(input int val, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      s[wp] = DW'(val);
      wp++;
    end
  endtask

  // Event segmentation from the pulse rules: an event is a run of over-threshold samples whose
  // below-threshold gaps are at most HOLDOFF long; after HOLDOFF+1 quiet samples the next cycle
  // commits it and that cycle's sample is not looked at.  A disabled edge abandons the event.
  task automatic build_events(input int n, input logic signed [DW-1:0] th);
    int i; int j; int gap; int w; int mt; bit pl; bit done;
    logic signed [DW-1:0] mx;
    n_ev = 0;
    for (int k = 0; k < MAXN; k++) cmt_idx[k] = -1;
    i = 0;
    while (i < n) begin
      if (en[i+1] && s[i] > th) begin
        mx = s[i]; mt = i; w = 1; pl = 1'b0; gap = 0; done = 1'b0; j = i + 1;
        while (!done && j < n) begin
          if (!en[j+1]) begin
            done = 1'b1; i = j + 1;
          end else if (gap == HOLDOFF + 1) begin
            if (n_ev < MAXEV) begin
              ev_h[n_ev] = mx; ev_t[n_ev] = mt; ev_p[n_ev] = pl;
              cmt_idx[j] = n_ev;
              n_ev++;
            end
            done = 1'b1; i = j + 1;
          end else if (s[j] > th) begin
            if (gap > 0) pl = 1'b1;
            gap = 0;
            w++;
            if (w >= MAX_WIDTH) pl = 1'b1;
            if (s[j] > mx) begin mx = s[j]; mt = j; end
          end else begin
            gap++;
          end
          j++;
        end
        if (!done) i = n;
      end else begin
        i++;
      end
    end
  endtask

  // Reset, then play n samples; the output slot is modelled edge by edge and compared each cycle.
  task automatic run_scn(input int n, input logic signed [DW-1:0] th);
    bit mv; bit mp; bit acc; int e;
    logic [DW-1:0] mh; logic [TS_W-1:0] mt;
    logic [CNT_W-1:0] mev; logic [CNT_W-1:0] mdr;
    build_events(n, th);
    rst = 1'b0; enable = 1'b0; peak_ready = 1'b0; shaped_in = '0; thresh = th;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid",  peak_valid,  0);
    check_eq("rst_height", peak_height, 0);
    check_eq("rst_time",   peak_time,   0);
    check_eq("rst_pileup", peak_pileup, 0);
    check_eq("rst_events", event_count, 0);
    check_eq("rst_drops",  drop_count,  0);
    mv = 1'b0; mp = 1'b0; mh = '0; mt = '0; mev = '0; mdr = '0;
    rise_m = -1; d_h = '0;
    for (int m = 0; m < n; m++) begin
      rst = 1'b1; enable = en[m]; shaped_in = s[m]; peak_ready = rdy[m];
      @(posedge clk);
      acc = mv && rdy[m];
      if (m > 0 && cmt_idx[m-1] >= 0) begin
        e = cmt_idx[m-1];
        if (!mv || acc) begin
          mv = 1'b1; mh = ev_h[e]; mt = TS_W'(ev_t[e]); mp = ev_p[e];
          if (mev != '1) mev++;
        end else begin
          if (mdr != '1) mdr++;
        end
      end else if (acc) begin
        mv = 1'b0;
      end
      @(negedge clk);
      check_eq("valid", peak_valid, mv);
      if (mv) begin
        check_eq("height", peak_height, mh);
        check_eq("time",   peak_time,   mt);
        check_eq("pileup", peak_pileup, mp);
      end
      check_eq("events", event_count, mev);
      check_eq("drops",  drop_count,  mdr);
      if (peak_valid) begin
        if (rise_m < 0) rise_m = m;
        d_h = peak_height;
      end
    end
  endtask

  // Alternating over/under-threshold runs; some gaps sit right around the hold-off boundary.
  task automatic gen_random(input int n, input int th, input int rdy_pct, input bit use_en);
    int i; int len; int v;
    clear_stim();
    i = 0;
    while (i < n - 60) begin
      len = 1 + int'($urandom_range(0, 39));
      for (int k = 0; k < len && i < n - 60; k++) begin
        v = th + 1 + int'($urandom_range(0, 8190 - th));
        s[i] = DW'(v); i++;
      end
      len = ($urandom_range(0, 3) == 0) ? 15 + int'($urandom_range(0, 5)) : 1 + int'($urandom_range(0, 24));
      for (int k = 0; k < len && i < n - 60; k++) begin
        v = ($urandom_range(0, 3) == 0) ? th : th - int'($urandom_range(0, 300));
        s[i] = DW'(v); i++;
      end
    end
    while (i < n) begin
      s[i] = DW'(th - int'($urandom_range(1, 300))); i++;
    end
    for (int m = 0; m < n; m++) begin
      rdy[m] = (int'($urandom_range(0, 99)) < rdy_pct);
      if (use_en && m > 0) en[m] = ($urandom_range(0, 199) != 0);
    end
  endtask

  initial begin
    int fall_idx; int k2;
    rst = 1'b0; enable = 1'b0; shaped_in = '0; thresh = '0; peak_ready = 1'b0;

    // Single trapezoid, thresh 100, always ready.
    clear_stim();
    add(0, 10);
    for (int k = 0; k < 50; k++) add(1000 * (k + 1) / 50, 1);
    add(1000, 200);
    fall_idx = -1;
    for (int k = 0; k < 50; k++) begin
      if (fall_idx < 0 && (1000 - 1000 * (k + 1) / 50) <= 100) fall_idx = wp;
      add(1000 - 1000 * (k + 1) / 50, 1);
    end
    add(0, 90);
    for (int m = 0; m < wp; m++) rdy[m] = 1'b1;
    run_scn(wp, 14'sd100);
    check_eq("single_events",  event_count, 1);
    check_eq("single_height",  d_h, 1000);
    check_eq("single_latency", rise_m, fall_idx + HOLDOFF + 2);

    // Negative threshold, baseline exactly at threshold, flat top of equal values.
    clear_stim();
    add(-50, 20);
    for (int k = 0; k < 10; k++) add(-50 + 350 * (k + 1) / 10, 1);
    add(300, 20);
    add(-50, 80);
    for (int m = 0; m < wp; m++) rdy[m] = 1'b1;
    run_scn(wp, -14'sd50);
    check_eq("tie_events", event_count, 1);
    check_eq("tie_height", d_h, 300);

    // Two pulses separated by a short gap merge into one pile-up event.
    clear_stim();
    add(0, 10); add(500, 30); add(0, 5); add(800, 30); add(0, 60);
    for (int m = 0; m < wp; m++) rdy[m] = 1'b1;
    run_scn(wp, 14'sd100);
    check_eq("merge_events", event_count, 1);
    check_eq("merge_height", d_h, 800);
    check_eq("merge_pileup", peak_pileup, 1);

    // Over-long pulse is flagged by width.
    clear_stim();
    add(0, 10); add(600, 430); add(0, 60);
    for (int m = 0; m < wp; m++) rdy[m] = 1'b1;
    run_scn(wp, 14'sd100);
    check_eq("long_pileup", peak_pileup, 1);

    // Consumer stalled across three pulses, then released.
    clear_stim();
    add(0, 10); add(300, 20); add(0, 40); add(600, 20); add(0, 40); add(900, 20); add(0, 60);
    for (int m = 200; m < wp; m++) rdy[m] = 1'b1;
    run_scn(wp, 14'sd100);
    check_eq("bp_events", event_count, 1);
    check_eq("bp_drops",  drop_count, 2);
    check_eq("bp_held",   d_h, 300);
    check_eq("bp_valid",  peak_valid, 0);

    // Accept of the first event lands on the same edge that loads the second.
    clear_stim();
    add(0, 10); add(400, 20); add(0, 40); add(700, 20); add(0, 60);
    build_events(wp, 14'sd100);
    k2 = -1;
    for (int k = 0; k < wp; k++) if (cmt_idx[k] == 1) k2 = k;
    if (k2 >= 0) rdy[k2 + 1] = 1'b1;
    run_scn(wp, 14'sd100);
    check_eq("simul_events", event_count, 2);
    check_eq("simul_drops",  drop_count, 0);
    check_eq("simul_height", peak_height, 700);
    check_eq("simul_valid",  peak_valid, 1);

    // Reset while an event is being presented.
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_valid",  peak_valid,  0);
    check_eq("midrst_height", peak_height, 0);
    check_eq("midrst_time",   peak_time,   0);
    check_eq("midrst_pileup", peak_pileup, 0);
    check_eq("midrst_events", event_count, 0);
    check_eq("midrst_drops",  drop_count,  0);

    // Enable dropped mid-rise and held low until the pulse is gone.
    clear_stim();
    add(0, 10);
    for (int k = 0; k < 20; k++) add(1000 * (k + 1) / 20, 1);
    add(1000, 40);
    for (int k = 0; k < 20; k++) add(1000 - 1000 * (k + 1) / 20, 1);
    add(0, 60);
    for (int m = 0; m < wp; m++) rdy[m] = 1'b1;
    for (int m = 20; m < 96; m++) en[m] = 1'b0;
    run_scn(wp, 14'sd100);
    check_eq("en_events", event_count, 0);
    check_eq("en_drops",  drop_count, 0);

    // Randomized run streams with varying threshold, consumer rate and enable glitches.
    for (int r = 0; r < 6; r++) begin
      int th;
      th = int'($urandom_range(0, 700)) - 200;
      gen_random(1200, th, (r == 0) ? 100 : (r == 1) ? 10 : int'($urandom_range(20, 90)), (r >= 4));
      run_scn(1200, DW'(th));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pulse_peak_detector.md
Name: pulse_peak_detector

Overview:
- Sits directly downstream of the trapezoidal shaper; consumes its 14-bit signed shaped output one sample per clock.
- Detects threshold-crossing pulses, captures the peak (flat-top maximum) height and a timestamp, and flags pile-up.
- Hands each event to the spectrum/histogram stage over a valid/ready handshake, with a one-entry output buffer and a drop counter.

Parameters:
- DW, 14, sample and height width (signed two's complement)
- HOLDOFF, 16, cycles after falling below threshold before an event is committed
- MAX_WIDTH, 420, maximum over-threshold cycles before pile-up is declared (shaper k+l+k plus margin)
- TS_W, 32, timestamp counter width
- CNT_W, 16, event/drop counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- enable  in  1  detection enable
- shaped_in  in  DW  signed shaped sample, valid every cycle
- thresh  in  DW  signed trigger threshold, sampled every cycle
- peak_valid  out  1  event available
- peak_ready  in  1  consumer accepts event
- peak_height  out  DW  signed maximum sample of event
- peak_time  out  TS_W  timestamp of the maximum sample
- peak_pileup  out  1  event flagged as pile-up
- event_count  out  CNT_W  events committed to output buffer
- drop_count  out  CNT_W  events lost because buffer was full

Behaviour:
- Reset (rst==0 at posedge): FSM=IDLE; peak_valid=0; peak_height=0; peak_time=0; peak_pileup=0; event_count=0; drop_count=0; timestamp=0; s_q=0.
- shaped_in registered once (s_q); the FSM acts on s_q. The timestamp counter increments every cycle and wraps modulo 2^TS_W. Each s_q is tagged with the timestamp value of the cycle it was registered.
- The trigger condition is signed(s_q) > signed(thresh) (strict inequality).
- IDLE: on trigger -> RISE; load max=s_q, max_ts=tag, width=1, pile=0.
- RISE: on each cycle with trigger, width++; if s_q > max (strict, first maximum wins), update max and max_ts. If width reaches MAX_WIDTH, set pile=1 and stay in RISE. When trigger is lost -> HOLD with hcnt=0.
- HOLD: hcnt++ every cycle.
  - Trigger again -> pile=1, back to RISE; max and width continue and are not reloaded.
  - hcnt==HOLDOFF-1 without trigger -> COMMIT.
- COMMIT (one cycle): try to load the output buffer, then -> IDLE.
  - Load succeeds if peak_valid==0 or (peak_valid & peak_ready) this cycle. On success: peak_height=max, peak_time=max_ts, peak_pileup=pile, peak_valid=1 next cycle, event_count++.
  - Otherwise the buffer is unchanged and drop_count++.
  - A trigger seen in the COMMIT cycle is ignored; IDLE re-evaluates it on the next cycle.
- Output handshake:
  - peak_valid stays high and peak_* stay stable until a cycle with peak_ready=1, then peak_valid clears the next cycle, unless a COMMIT loads in the same cycle, in which case it stays 1 with the new data.
  - peak_ready while peak_valid=0 is ignored.
- Latency: peak_valid rises on the 2nd posedge after the COMMIT cycle starts, i.e. HOLDOFF+2 cycles after the first below-threshold s_q.
- Counters saturate at all-ones (no wrap).
- enable=0: FSM forced to IDLE next cycle and any in-flight event is abandoned without counting. The output buffer, handshake, counters and timestamp keep operating.
- Reset mid-event or mid-handshake: everything returns to reset values and the pending event is lost.
- thresh changes take effect on the next compare; no retroactive effect.

Decomposition:
- Shared package (shaper_pkg): DW, TS_W, CNT_W defaults; FSM state enum {IDLE, RISE, HOLD, COMMIT}; saturating-increment function.
- One natural sub-module: peak_out_buffer (single-entry valid/ready register with load/accept/drop logic).
- FSM, timestamp and max tracking stay in the top module.

Test Plan:
- Single pulse: thresh=100, trapezoid 0->1000 flat 200 cycles ->0; ready=1 -> one event, height=1000, peak_time = first 1000 sample's tag, pileup=0, event_count=1, valid asserted HOLDOFF+2 after fall.
- Tie/negative: thresh=-50, flat-top of equal values -> peak_time at first max sample; samples at exactly -50 never trigger.
- Pile-up: two pulses 500 and 800, gap of 5 cycles below threshold (<HOLDOFF) -> one event, height=800, pileup=1; and a 430-cycle continuous over-threshold pulse -> pileup=1.
- Back-pressure: ready=0, three separated pulses -> first event held stable, drop_count=2, event_count=1; raise ready -> valid drops next cycle.
- Simultaneous accept+commit: ready pulsed in the exact COMMIT cycle -> new event loaded, valid stays 1, drop_count unchanged.
- Reset/enable: enable=0 mid-RISE -> no event, counters unchanged; rst=0 while valid=1 -> all outputs 0 next cycle.
